cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
Shares the single common data bus (CDB) between the two result producers: the ALU reservation station and the load/store buffer. Each source has a small FIFO, and a round-robin arbiter broadcasts at most one result per cycle to the ROB, the RS and the LSB. On mispredict, all pending results are flushed. Sits between the RS/LSB result ports and every CDB consumer.

Parameters:
DATA_W, 32, result value width
ADDR_W, 32, PC width
ROB_ID_W, 5, ROB tag width
DEPTH, 2, per-source FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; low = freeze all state
mispredict  in  1  flush request from ROB
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this edge if alu_valid
alu_rob_id  in  ROB_ID_W  ALU result tag
alu_value  in  DATA_W  ALU result
alu_jump  in  1  branch/jump taken
alu_pc_next  in  ADDR_W  resolved next PC
lsb_valid  in  1  LSB result offered
lsb_ready  out  1  LSB result accepted this edge if lsb_valid
lsb_rob_id  in  ROB_ID_W  LSB result tag
lsb_value  in  DATA_W  load result
cdb_valid  out  1  broadcast valid
cdb_src  out  1  0 = ALU, 1 = LSB
cdb_rob_id  out  ROB_ID_W  broadcast tag
cdb_value  out  DATA_W  broadcast value
cdb_jump  out  1  taken flag (0 for LSB)
cdb_pc_next  out  ADDR_W  next PC (0 for LSB)

Behaviour:
- Reset: both FIFOs empty. last_grant = ALU, so LSB wins the first tie. All cdb_* outputs are 0.
- x_ready = rdy && !mispredict && count_x < DEPTH. This is combinational from state. A pop in the same cycle never raises ready.
- Push: on an edge with x_valid && x_ready, the entry is captured.
- Candidate per source: the FIFO head if the FIFO is non-empty; otherwise the incoming accepted entry (bypass). A bypassed entry that loses arbitration is written into its FIFO.
- Arbitration, per rdy cycle:
  - one candidate: grant it;
  - two candidates: grant the source != last_grant;
  - after any grant, last_grant is set to the granted source.
- Output: cdb_* are registered. The granted entry drives cdb_* for exactly one cycle after the edge, with cdb_valid = 1. With no candidate, cdb_valid <= 0 and the other cdb_* fields hold their last values.
- Latency: accepted at edge E with an empty FIFO and a won arbitration -> visible in the cycle after E. Each lost arbitration adds 1 cycle.
- Ordering: results from one source are broadcast in acceptance order. There is no ordering guarantee across sources.
- Throughput: 1 broadcast per cycle. A source is never starved: with both sources busy, grants alternate.
- Mispredict (sampled with rdy = 1):
  - both FIFOs cleared;
  - inputs at that edge are not accepted;
  - cdb_valid <= 0;
  - last_grant unchanged.
- rdy = 0: no push, no pop, cdb_* hold, last_grant holds, and both readies are 0.
- rst wins over rdy and mispredict. A reset mid-stream drops all pending entries.
- FIFO pointers wrap modulo DEPTH. count is in 0..DEPTH.

Test Plan:
1. From reset: alu_valid=1 for one cycle, rob_id=3, value=0x11, jump=1, pc_next=0x100 -> next cycle cdb_valid=1, src=0, rob_id=3, value=0x11, jump=1, pc_next=0x100. The cycle after that, cdb_valid=0.
2. From reset: ALU (id 1) and LSB (id 2) offered at the same edge -> cycle+1 broadcasts id 2 (src=1, jump=0, pc_next=0). Cycle+2 broadcasts id 1.
3. Both sources stream continuously, ALU ids 0..5 and LSB ids 8..13 -> broadcasts strictly alternate. Per-source order is preserved. No id is lost or duplicated. Readies drop whenever count hits 2.
4. Fill the ALU FIFO (2 entries pending, LSB also busy), then pulse mispredict -> the cycle after, cdb_valid=0 and alu_ready and lsb_ready are 0 during the pulse. No flushed id ever appears; a new ALU id 7 is broadcast with 1-cycle latency.
5. Hold rdy=0 for 3 cycles with one entry pending and valid inputs asserted -> cdb outputs frozen, readies 0, nothing accepted. After rdy returns, the pending entry broadcasts first.
6. Assert rst while 3 entries are pending -> the next cycle all cdb_* are 0 and both readies are 1. The first subsequent tie is granted to LSB.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs with bypass, round-robin
// selection between ALU and LSB, one registered broadcast per cycle.

module cdb_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    // Storage carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && en && !flush && push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (en) begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

endmodule

module cdb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ROB_ID_W = 5,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                mispredict,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]   alu_value,
    input  logic                alu_jump,
    input  logic [ADDR_W-1:0]   alu_pc_next,
    input  logic                lsb_valid,
    output logic                lsb_ready,
    input  logic [ROB_ID_W-1:0] lsb_rob_id,
    input  logic [DATA_W-1:0]   lsb_value,
    output logic                cdb_valid,
    output logic                cdb_src,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_W-1:0]   cdb_value,
    output logic                cdb_jump,
    output logic [ADDR_W-1:0]   cdb_pc_next
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ALU_W = ROB_ID_W + DATA_W + 1 + ADDR_W;
    localparam int LSB_W = ROB_ID_W + DATA_W;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    logic             active;
    logic             last_grant;

    logic [ALU_W-1:0] alu_in;
    logic [ALU_W-1:0] alu_head;
    logic [ALU_W-1:0] alu_cand_data;
    logic [CNT_W-1:0] alu_count;
    logic             alu_push;
    logic             alu_has_head;
    logic             alu_cand;
    logic             alu_pop;
    logic             alu_wr;

    logic [LSB_W-1:0] lsb_in;
    logic [LSB_W-1:0] lsb_head;
    logic [LSB_W-1:0] lsb_cand_data;
    logic [CNT_W-1:0] lsb_count;
    logic             lsb_push;
    logic             lsb_has_head;
    logic             lsb_cand;
    logic             lsb_pop;
    logic             lsb_wr;

    logic             grant_alu;
    logic             grant_lsb;

    assign active    = rdy && !mispredict;
    assign alu_ready = active && (alu_count < CNT_W'(DEPTH));
    assign lsb_ready = active && (lsb_count < CNT_W'(DEPTH));

    assign alu_in   = {alu_rob_id, alu_value, alu_jump, alu_pc_next};
    assign lsb_in   = {lsb_rob_id, lsb_value};
    assign alu_push = alu_valid && alu_ready;
    assign lsb_push = lsb_valid && lsb_ready;

    assign alu_has_head = (alu_count != '0);
    assign lsb_has_head = (lsb_count != '0);

    // A source with an empty FIFO competes with its incoming entry directly.
    always_comb begin
        alu_cand      = alu_has_head || alu_push;
        lsb_cand      = lsb_has_head || lsb_push;
        alu_cand_data = alu_has_head ? alu_head : alu_in;
        lsb_cand_data = lsb_has_head ? lsb_head : lsb_in;

        grant_alu = active && alu_cand && (!lsb_cand || last_grant == SRC_LSB);
        grant_lsb = active && lsb_cand && !grant_alu;

        alu_pop = grant_alu && alu_has_head;
        lsb_pop = grant_lsb && lsb_has_head;
        alu_wr  = alu_push && !(grant_alu && !alu_has_head);
        lsb_wr  = lsb_push && !(grant_lsb && !lsb_has_head);
    end

    cdb_result_fifo #(
        .WIDTH (ALU_W),
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .flush (mispredict),
        .push  (alu_wr),
        .pop   (alu_pop),
        .wdata (alu_in),
        .head  (alu_head),
        .count (alu_count)
    );

    cdb_result_fifo #(
        .WIDTH (LSB_W),
        .DEPTH (DEPTH)
    ) u_lsb_fifo (
        .clk   (clk),
        .rst   (rst),
        .en    (rdy),
        .flush (mispredict),
        .push  (lsb_wr),
        .pop   (lsb_pop),
        .wdata (lsb_in),
        .head  (lsb_head),
        .count (lsb_count)
    );

    // Without a grant only cdb_valid drops; payload fields keep the last broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid   <= 1'b0;
            cdb_src     <= SRC_ALU;
            cdb_rob_id  <= '0;
            cdb_value   <= '0;
            cdb_jump    <= 1'b0;
            cdb_pc_next <= '0;
            last_grant  <= SRC_ALU;
        end else if (rdy) begin
            if (mispredict) begin
                cdb_valid <= 1'b0;
            end else if (grant_alu) begin
                cdb_valid   <= 1'b1;
                cdb_src     <= SRC_ALU;
                cdb_rob_id  <= alu_cand_data[ALU_W-1 -: ROB_ID_W];
                cdb_value   <= alu_cand_data[ADDR_W+DATA_W : ADDR_W+1];
                cdb_jump    <= alu_cand_data[ADDR_W];
                cdb_pc_next <= alu_cand_data[ADDR_W-1:0];
                last_grant  <= SRC_ALU;
            end else if (grant_lsb) begin
                cdb_valid   <= 1'b1;
                cdb_src     <= SRC_LSB;
                cdb_rob_id  <= lsb_cand_data[LSB_W-1 -: ROB_ID_W];
                cdb_value   <= lsb_cand_data[DATA_W-1:0];
                cdb_jump    <= 1'b0;
                cdb_pc_next <= '0;
                last_grant  <= SRC_LSB;
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts the
// broadcast of every cycle; predictions are queued on drive and popped after the edge.

module tb_cdb_arbiter;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic        valid;
        logic        src;
        logic [4:0]  id;
        logic [31:0] value;
        logic        jump;
        logic [31:0] pc;
    } cdb_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] value;
        logic        jump;
        logic [31:0] pc;
    } alu_e_t;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] value;
    } lsb_e_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        mispredict;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rob_id;
    logic [31:0] alu_value;
    logic        alu_jump;
    logic [31:0] alu_pc_next;
    logic        lsb_valid;
    logic        lsb_ready;
    logic [4:0]  lsb_rob_id;
    logic [31:0] lsb_value;
    logic        cdb_valid;
    logic        cdb_src;
    logic [4:0]  cdb_rob_id;
    logic [31:0] cdb_value;
    logic        cdb_jump;
    logic [31:0] cdb_pc_next;

    alu_e_t alu_q[$];
    lsb_e_t lsb_q[$];
    cdb_t   sb[$];
    cdb_t   m_cdb;
    logic   m_last;
    logic   acc_a;
    logic   acc_l;
    int     checks_total;
    int     checks_passed;

    always #5 clk = ~clk;

    cdb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .ROB_ID_W (5),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .mispredict  (mispredict),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rob_id  (alu_rob_id),
        .alu_value   (alu_value),
        .alu_jump    (alu_jump),
        .alu_pc_next (alu_pc_next),
        .lsb_valid   (lsb_valid),
        .lsb_ready   (lsb_ready),
        .lsb_rob_id  (lsb_rob_id),
        .lsb_value   (lsb_value),
        .cdb_valid   (cdb_valid),
        .cdb_src     (cdb_src),
        .cdb_rob_id  (cdb_rob_id),
        .cdb_value   (cdb_value),
        .cdb_jump    (cdb_jump),
        .cdb_pc_next (cdb_pc_next)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks_total++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
        end else begin
            checks_passed++;
        end
    endtask

    // Drives one cycle, checks readies before the edge, advances the model,
    // and compares the registered broadcast just after the edge.
    task automatic applyStimulus(
        input logic        i_rst,
        input logic        i_rdy,
        input logic        i_mp,
        input logic        i_av,
        input logic [4:0]  i_aid,
        input logic [31:0] i_aval,
        input logic        i_aj,
        input logic [31:0] i_apc,
        input logic        i_lv,
        input logic [4:0]  i_lid,
        input logic [31:0] i_lval
    );
        logic   exp_ar;
        logic   exp_lr;
        logic   ca;
        logic   cl;
        alu_e_t ae;
        lsb_e_t le;
        cdb_t   exp;

        rst         = i_rst;
        rdy         = i_rdy;
        mispredict  = i_mp;
        alu_valid   = i_av;
        alu_rob_id  = i_aid;
        alu_value   = i_aval;
        alu_jump    = i_aj;
        alu_pc_next = i_apc;
        lsb_valid   = i_lv;
        lsb_rob_id  = i_lid;
        lsb_value   = i_lval;
        #1;

        exp_ar = i_rdy && !i_mp && (alu_q.size() < DEPTH);
        exp_lr = i_rdy && !i_mp && (lsb_q.size() < DEPTH);
        checkOutput("alu_ready", 64'(alu_ready), 64'(exp_ar));
        checkOutput("lsb_ready", 64'(lsb_ready), 64'(exp_lr));
        acc_a = !i_rst && i_av && exp_ar;
        acc_l = !i_rst && i_lv && exp_lr;

        if (i_rst) begin
            alu_q.delete();
            lsb_q.delete();
            m_last = 1'b0;
            m_cdb  = '0;
        end else if (i_rdy) begin
            if (i_mp) begin
                alu_q.delete();
                lsb_q.delete();
                m_cdb.valid = 1'b0;
            end else begin
                if (acc_a) alu_q.push_back('{id: i_aid, value: i_aval, jump: i_aj, pc: i_apc});
                if (acc_l) lsb_q.push_back('{id: i_lid, value: i_lval});
                ca = (alu_q.size() > 0);
                cl = (lsb_q.size() > 0);
                if (ca && (!cl || m_last == 1'b1)) begin
                    ae = alu_q.pop_front();
                    m_cdb = '{valid: 1'b1, src: 1'b0, id: ae.id, value: ae.value, jump: ae.jump, pc: ae.pc};
                    m_last = 1'b0;
                end else if (cl) begin
                    le = lsb_q.pop_front();
                    m_cdb = '{valid: 1'b1, src: 1'b1, id: le.id, value: le.value, jump: 1'b0, pc: 32'h0};
                    m_last = 1'b1;
                end else begin
                    m_cdb.valid = 1'b0;
                end
            end
        end
        sb.push_back(m_cdb);

        @(posedge clk);
        #1;
        exp = sb.pop_front();
        checkOutput("cdb_valid",   64'(cdb_valid),   64'(exp.valid));
        checkOutput("cdb_src",     64'(cdb_src),     64'(exp.src));
        checkOutput("cdb_rob_id",  64'(cdb_rob_id),  64'(exp.id));
        checkOutput("cdb_value",   64'(cdb_value),   64'(exp.value));
        checkOutput("cdb_jump",    64'(cdb_jump),    64'(exp.jump));
        checkOutput("cdb_pc_next", 64'(cdb_pc_next), 64'(exp.pc));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    // Both sources offered together for n cycles with ids counting from the bases.
    task automatic bothBusy(input int n, input int alu_base, input int lsb_base);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0,
                          1'b1, 5'(alu_base + k), 32'(32'hA000 + k), 1'b1, 32'(32'h400 + 4 * k),
                          1'b1, 5'(lsb_base + k), 32'(32'hB000 + k));
        end
    endtask

    initial begin
        int na;
        int nl;
        int guard;

        checks_total  = 0;
        checks_passed = 0;
        m_cdb  = '0;
        m_last = 1'b0;

        rst = 1'b1; rdy = 1'b1; mispredict = 1'b0;
        alu_valid = 1'b0; alu_rob_id = '0; alu_value = '0; alu_jump = 1'b0; alu_pc_next = '0;
        lsb_valid = 1'b0; lsb_rob_id = '0; lsb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'd0);
        checkOutput("reset_cdb_src",   64'(cdb_src),   64'd0);
        checkOutput("reset_cdb_id",    64'(cdb_rob_id), 64'd0);
        checkOutput("reset_cdb_value", 64'(cdb_value), 64'd0);
        checkOutput("reset_cdb_jump",  64'(cdb_jump),  64'd0);
        checkOutput("reset_cdb_pc",    64'(cdb_pc_next), 64'd0);
        checkOutput("reset_alu_ready", 64'(alu_ready), 64'd1);
        checkOutput("reset_lsb_ready", 64'(lsb_ready), 64'd1);

        $display("[TB] single ALU result");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 32'h100, 1'b0, 5'd0, 32'h0);
        checkOutput("t1_src_alu", 64'(cdb_src), 64'd0);
        idle(1);
        checkOutput("t1_valid_drop", 64'(cdb_valid), 64'd0);

        $display("[TB] first tie goes to LSB");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h21, 1'b1, 32'h204, 1'b1, 5'd2, 32'h22);
        checkOutput("t2_first_id", 64'(cdb_rob_id), 64'd2);
        idle(1);
        checkOutput("t2_second_id", 64'(cdb_rob_id), 64'd1);
        idle(1);

        $display("[TB] two continuous streams");
        doReset();
        na = 0;
        nl = 0;
        guard = 0;
        while ((na < 6 || nl < 6) && guard < 40) begin
            applyStimulus(1'b0, 1'b1, 1'b0,
                          na < 6, 5'(na), 32'(32'h1000 + na), na[0], 32'(32'h200 + 4 * na),
                          nl < 6, 5'(8 + nl), 32'(32'h2000 + nl));
            if (acc_a) na++;
            if (acc_l) nl++;
            guard++;
        end
        checkOutput("t3_all_alu_accepted", 64'(na), 64'd6);
        checkOutput("t3_all_lsb_accepted", 64'(nl), 64'd6);
        idle(4);

        $display("[TB] mispredict flush");
        doReset();
        bothBusy(3, 20, 24);
        checkOutput("t4_alu_pending", 64'(alu_q.size()), 64'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd30, 32'h30, 1'b0, 32'h300, 1'b1, 5'd31, 32'h31);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b1, 32'h700, 1'b0, 5'd0, 32'h0);
        checkOutput("t4_new_id", 64'(cdb_rob_id), 64'd7);
        idle(3);

        $display("[TB] rdy stall");
        doReset();
        bothBusy(1, 4, 12);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 32'h900, 1'b1, 5'd10, 32'hAA);
        end
        idle(1);
        checkOutput("t5_pending_first", 64'(cdb_rob_id), 64'd4);
        idle(2);

        $display("[TB] reset mid-stream");
        doReset();
        bothBusy(3, 1, 16);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 1'b1, 32'h500, 1'b1, 5'd6, 32'h66);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 5'd17, 32'h17, 1'b0, 32'h170, 1'b1, 5'd18, 32'h18);
        checkOutput("t6_tie_lsb", 64'(cdb_src), 64'd1);
        idle(2);

        $display("[TB] random traffic");
        doReset();
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                          1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(4);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
